// File: rtl/control_unit_pkg.sv
// Shared definitions for the instruction-sequencing controller: state encoding,
// opcode constants and instruction-register field positions.
package control_unit_pkg;

  typedef enum logic [3:0] {
    StReset  = 4'd0,
    StFetch0 = 4'd1,
    StFetch1 = 4'd2,
    StFetch2 = 4'd3,
    StEx3    = 4'd4,
    StEx4    = 4'd5,
    StEx5    = 4'd6,
    StEx6    = 4'd7,
    StHalt   = 4'd8
  } state_e;

  // Instruction register field positions
  localparam int unsigned OpcodeMsb = 31;
  localparam int unsigned OpcodeLsb = 27;
  localparam int unsigned RaMsb     = 26;
  localparam int unsigned RaLsb     = 23;
  localparam int unsigned RbMsb     = 22;
  localparam int unsigned RbLsb     = 19;
  localparam int unsigned RcMsb     = 18;
  localparam int unsigned RcLsb     = 15;

  localparam int unsigned OpcodeW = OpcodeMsb - OpcodeLsb + 1;
  localparam int unsigned AluOpW  = 4;

  typedef logic [OpcodeW-1:0] opcode_t;

  localparam opcode_t OpAdd = 5'b00011;
  localparam opcode_t OpSub = 5'b00100;
  localparam opcode_t OpAnd = 5'b00101;
  localparam opcode_t OpOr  = 5'b00110;
  localparam opcode_t OpShr = 5'b00111;
  localparam opcode_t OpShl = 5'b01000;
  localparam opcode_t OpRor = 5'b01001;
  localparam opcode_t OpRol = 5'b01010;
  localparam opcode_t OpMul = 5'b01111;
  localparam opcode_t OpDiv = 5'b10000;
  localparam opcode_t OpNeg = 5'b10001;
  localparam opcode_t OpNot = 5'b10010;

  function automatic logic [AluOpW-1:0] alu_code(input opcode_t op);
    return op[AluOpW-1:0];
  endfunction

endpackage

// File: rtl/opcode_decode.sv
// Classifies an opcode into binary / unary / mul-div groups and produces the
// ALU function code (zero for unrecognised opcodes).
module opcode_decode
  import control_unit_pkg::*;
(
  input  logic [OpcodeW-1:0] opcode,
  output logic               is_binary,
  output logic               is_unary,
  output logic               is_muldiv,
  output logic               is_valid,
  output logic [AluOpW-1:0]  operation
);

  always_comb begin
    is_binary = 1'b0;
    is_unary  = 1'b0;
    is_muldiv = 1'b0;
    case (opcode)
      OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShl, OpRor, OpRol: is_binary = 1'b1;
      OpMul, OpDiv:                                          is_muldiv = 1'b1;
      OpNeg, OpNot:                                          is_unary  = 1'b1;
      default: ;
    endcase
    is_valid  = is_binary | is_unary | is_muldiv;
    operation = is_valid ? alu_code(opcode) : '0;
  end

endmodule

// File: rtl/control_unit.sv
// Moore-style sequencer driving datapath strobes through fetch and up to four
// execute steps; halts on a Stop request sampled at FETCH0.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        Mem_ready,
  input  logic        Stop,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin_low,
  output logic        Zin_high,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [3:0]  operation,
  output logic        Run
);

  state_e state_q, state_d;
  // Set while the previous cycle was also FETCH1, so PCin pulses only once
  logic fetch1_seen_q, fetch1_seen_d;

  logic              is_binary, is_unary, is_muldiv, is_valid;
  logic [AluOpW-1:0] dec_op;

  logic unused_ir;
  assign unused_ir = ^{IR[OpcodeLsb-1:0], is_valid};

  opcode_decode u_opcode_decode (
    .opcode    (IR[OpcodeMsb:OpcodeLsb]),
    .is_binary (is_binary),
    .is_unary  (is_unary),
    .is_muldiv (is_muldiv),
    .is_valid  (is_valid),
    .operation (dec_op)
  );

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q       <= StReset;
      fetch1_seen_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch1_seen_q <= fetch1_seen_d;
    end
  end

  assign fetch1_seen_d = (state_q == StFetch1);

  always_comb begin
    state_d   = state_q;
    PCout     = 1'b0;
    PCin      = 1'b0;
    IncPC     = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    Read      = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin_low   = 1'b0;
    Zin_high  = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    operation = '0;
    Run       = (state_q != StReset) && (state_q != StHalt);

    unique case (state_q)
      StReset: state_d = StFetch0;
      StFetch0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin_low = 1'b1;
        state_d = Stop ? StHalt : StFetch1;
      end
      StFetch1: begin
        Zlowout = 1'b1;
        PCin    = !fetch1_seen_q;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (Mem_ready) state_d = StFetch2;
      end
      StFetch2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = StEx3;
      end
      StEx3: begin
        if (is_binary || is_muldiv) begin
          Grb     = 1'b1;
          Rout    = 1'b1;
          Yin     = 1'b1;
          state_d = StEx4;
        end else if (is_unary) begin
          Grb       = 1'b1;
          Rout      = 1'b1;
          Zin_low   = 1'b1;
          operation = dec_op;
          state_d   = StEx5;
        end else begin
          state_d = StFetch0;
        end
      end
      StEx4: begin
        Grc       = 1'b1;
        Rout      = 1'b1;
        operation = dec_op;
        Zin_low   = is_binary | is_muldiv;
        Zin_high  = is_muldiv;
        state_d   = StEx5;
      end
      StEx5: begin
        if (is_muldiv) begin
          Zlowout = 1'b1;
          LOin    = 1'b1;
          state_d = StEx6;
        end else begin
          if (is_binary || is_unary) begin
            Zlowout = 1'b1;
            Gra     = 1'b1;
            Rin     = 1'b1;
          end
          state_d = StFetch0;
        end
      end
      StEx6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        state_d  = StFetch0;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StReset;
    endcase
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port Clock, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-002 SHALL have port clear, input, 1, reset; asynchronous and active-low.
REQ-003 SHALL have port IR, input, 32, the instruction register contents: opcode IR[31:27], ra IR[26:23], rb IR[22:19], rc IR[18:15].
REQ-004 SHALL have port Mem_ready, input, 1, memory read-complete acknowledge.
REQ-005 SHALL have port Stop, input, 1, halt request.
REQ-006 SHALL have datapath strobe outputs, each 1 bit: PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin_low, Zin_high, Zlowout, Zhighout, HIin, LOin.
REQ-007 SHALL have outputs Gra, Grb, Grc, Rin, Rout, each 1 bit, for the register select-and-encode logic.
REQ-008 SHALL have output operation, 4 bits, the ALU function code.
REQ-009 SHALL have output Run, 1 bit; high while the controller is executing.

Function
REQ-010 SHALL implement a Moore FSM with states RESET_S, FETCH0, FETCH1, FETCH2, EX3, EX4, EX5, EX6 and HALT_S.
- Outputs are decoded combinationally from the present state and IR.
- Every signal not listed for a state is 0.
REQ-011 RESET_S SHALL assert nothing and advance to FETCH0 on the next edge.
REQ-012 FETCH0 SHALL assert PCout, MARin, IncPC and Zin_low.
- If Stop = 1 at the edge, the next state is HALT_S; otherwise it is FETCH1.
REQ-013 FETCH1 SHALL assert Zlowout, PCin, Read and MDRin.
- PCin is asserted only in the first FETCH1 cycle.
- FETCH1 holds while Mem_ready = 0 and advances to FETCH2 on an edge with Mem_ready = 1.
REQ-014 FETCH2 SHALL assert MDRout and IRin, then go to EX3.
REQ-015 SHALL accept these opcodes, with operation = opcode[3:0]:
- Binary ops: add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010.
- Mul/div: mul 01111, div 10000.
- Unary ops: neg 10001, not 10010.
REQ-016 EX3 SHALL behave by opcode class:
- Binary ops and mul/div: assert Grb, Rout, Yin.
- Unary ops: assert Grb, Rout, Zin_low, operation, and next state is EX5.
- Any other opcode, including nop: assert nothing; next state is FETCH0.
REQ-017 EX4 SHALL assert Grc, Rout and operation, plus:
- Zin_low for binary ops;
- Zin_low and Zin_high for mul/div.
REQ-018 EX5 SHALL behave by opcode class:
- Binary and unary ops: assert Zlowout, Gra, Rin; next state is FETCH0.
- Mul/div: assert Zlowout, LOin; next state is EX6.
REQ-019 EX6 SHALL assert Zhighout and HIin, then go to FETCH0.
REQ-020 Instruction latency with Mem_ready held high SHALL be:
- 6 cycles for binary ops;
- 5 cycles for unary ops;
- 7 cycles for mul/div;
- 4 cycles for nop/unknown.
REQ-021 Each Mem_ready = 0 cycle in FETCH1 SHALL add exactly one cycle of latency.
REQ-022 Mem_ready SHALL be ignored outside FETCH1.
REQ-023 Stop SHALL be ignored outside FETCH0, so an instruction in progress always completes.
REQ-024 HALT_S SHALL assert nothing and drive Run = 0; it is left only by reset.
REQ-025 Run SHALL be 1 in every state except RESET_S and HALT_S.
REQ-026 IR SHALL be sampled only in EX3..EX6; IR changes during FETCH0..FETCH2 SHALL NOT affect outputs.

Reset
REQ-027 clear = 0 SHALL force RESET_S immediately, regardless of Clock and of the current state.
REQ-028 While clear = 0, all outputs SHALL be 0, including Run and operation.
REQ-029 After clear rises, the first rising edge SHALL move RESET_S to FETCH0.

Structure
REQ-030 A shared package SHALL hold:
- the state encoding constants;
- the opcode constants (REQ-015);
- the field bit positions (REQ-003).
REQ-031 A single sub-module, opcode_decode, SHALL be used.
- It maps opcode to class flags is_binary, is_unary, is_muldiv and is_valid.
- It drives the operation code.
REQ-032 No other sub-modules SHALL be used.

Verification
REQ-033 Reset: hold clear = 0 across 3 edges -> all outputs 0 and Run = 0; release -> FETCH0 strobes on the second edge after release.
REQ-034 shr, IR = 32'h3A918000 (opcode 00111, ra=5, rb=2, rc=3), Mem_ready = 1:
- EX3 Grb/Rout/Yin;
- EX4 Grc/Rout/Zin_low with operation = 4'b0111;
- EX5 Zlowout/Gra/Rin;
- back to FETCH0 after 6 cycles.
REQ-035 mul, IR opcode 01111:
- EX4 asserts Zin_low and Zin_high;
- EX5 Zlowout/LOin;
- EX6 Zhighout/HIin;
- 7 cycles total.
REQ-036 Wait states: Mem_ready = 0 for 3 cycles in FETCH1 -> FETCH1 lasts 4 cycles, PCin is high only in the first, Read/MDRin stay high throughout.
REQ-037 Stop:
- Stop = 1 during EX4 of add, then held -> add completes, next FETCH0 -> HALT_S, Run = 0, no further strobes.
- Unknown opcode 11111 -> FETCH0 after 4 cycles.
REQ-038 Reset mid-operation: clear = 0 between edges during EX4 -> outputs 0 immediately, no Rin pulse, restart at FETCH0.
